// File: rtl/det_window_counter.sv
// det_window_counter
//
// Windowed event counter for the 1100 sequence detector's detect pulse.
// Counts det pulses over back-to-back windows of WIN cycles. At each window
// close the (saturated) count is offered on a valid/ready slot, and a one-cycle
// alarm fires if it reaches thresh. A result that arrives while the slot is
// still occupied is dropped and recorded in the sticky overrun flag.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   det         detect pulse, sampled every edge while running
//   enable      1 = run windows, 0 = idle
//   thresh      alarm threshold, sampled at window close
//   cnt_out     count of the last completed window (stable while cnt_valid)
//   cnt_valid   cnt_out holds an unaccepted result
//   cnt_ready   consumer accepts when cnt_valid && cnt_ready at an edge
//   alarm       one-cycle pulse: closing count >= thresh
//   overrun     sticky: a window result was dropped
//   live_count  running count of the current window
module det_window_counter #(
  parameter int CW  = 8,
  parameter int WIN = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          det,
  input  logic          enable,
  input  logic [CW-1:0] thresh,
  output logic [CW-1:0] cnt_out,
  output logic          cnt_valid,
  input  logic          cnt_ready,
  output logic          alarm,
  output logic          overrun,
  output logic [CW-1:0] live_count
);

  localparam int              TW    = $clog2(WIN);
  localparam logic [TW-1:0]   TLAST = TW'(WIN - 1);
  localparam logic [CW-1:0]   CMAX  = '1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic [CW-1:0] live_q;
  logic [CW-1:0] out_q;
  logic          valid_q;
  logic          alarm_q;
  logic          ovr_q;

  logic          accept;
  logic          close;
  logic [CW-1:0] count_d;

  assign accept  = valid_q & cnt_ready;
  assign close   = (state_q == RUN) && (timer_q == TLAST);
  // Count including this edge's det, clamped at all-ones.
  assign count_d = (det && (live_q != CMAX)) ? live_q + CW'(1) : live_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      live_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      alarm_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      alarm_q <= 1'b0;
      // An accept frees the slot; a close on the same edge may refill it below.
      if (accept) valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          timer_q <= '0;
          live_q  <= '0;
          // det on the entry edge is deliberately not counted.
          if (enable) begin
            state_q <= RUN;
            ovr_q   <= 1'b0;
          end
        end

        RUN: begin
          if (close) begin
            // A close is honoured even if enable drops on the same edge.
            timer_q <= '0;
            live_q  <= '0;
            alarm_q <= (count_d >= thresh);
            if (!valid_q || accept) begin
              out_q   <= count_d;
              valid_q <= 1'b1;
            end else begin
              ovr_q   <= 1'b1;
            end
            if (!enable) state_q <= IDLE;
          end else if (!enable) begin
            // Partial window abandoned: no result, no alarm.
            state_q <= IDLE;
            timer_q <= '0;
            live_q  <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
            live_q  <= count_d;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign cnt_out    = out_q;
  assign cnt_valid  = valid_q;
  assign alarm      = alarm_q;
  assign overrun    = ovr_q;
  assign live_count = live_q;

endmodule

// File: tb/tb_det_window_counter.sv
module tb_det_window_counter;

  localparam int CW  = 4;
  localparam int WIN = 16;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          det = 1'b0;
  logic          enable = 1'b0;
  logic          cnt_ready = 1'b0;
  logic [CW-1:0] thresh = '0;
  logic [CW-1:0] cnt_out;
  logic          cnt_valid;
  logic          alarm;
  logic          overrun;
  logic [CW-1:0] live_count;

  int n_cmp = 0;
  int n_err = 0;

  det_window_counter #(.CW(CW), .WIN(WIN)) dut (
    .clk(clk), .reset(reset), .det(det), .enable(enable), .thresh(thresh),
    .cnt_out(cnt_out), .cnt_valid(cnt_valid), .cnt_ready(cnt_ready),
    .alarm(alarm), .overrun(overrun), .live_count(live_count)
  );

  always #5 clk = ~clk;

  // Reference model: unsaturated det tally plus an edge index within the
  // window (1..WIN); saturation is applied only when values are observed.
  bit m_run   = 0;
  int m_pos   = 0;
  int m_cnt   = 0;
  int m_out   = 0;
  bit m_valid = 0;
  bit m_alarm = 0;
  bit m_ovr   = 0;
  int fin;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 0; m_pos = 0; m_cnt = 0; m_out = 0;
      m_valid = 0; m_alarm = 0; m_ovr = 0;
    end else begin
      m_alarm = 0;
      if (m_valid && cnt_ready) m_valid = 0;
      if (!m_run) begin
        if (enable) begin
          m_run = 1; m_pos = 0; m_cnt = 0; m_ovr = 0;
        end
      end else begin
        m_pos = m_pos + 1;
        if (det) m_cnt = m_cnt + 1;
        if (m_pos == WIN) begin
          fin = (m_cnt > MAX) ? MAX : m_cnt;
          m_alarm = (fin >= int'(thresh));
          if (!m_valid) begin
            m_out = fin;
            m_valid = 1;
          end else begin
            m_ovr = 1;
          end
          m_pos = 0; m_cnt = 0;
          if (!enable) m_run = 0;
        end else if (!enable) begin
          m_run = 0; m_pos = 0; m_cnt = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m.cnt_out",    32'(cnt_out),    32'(m_out));
    chk("m.cnt_valid",  32'(cnt_valid),  32'(m_valid));
    chk("m.alarm",      32'(alarm),      32'(m_alarm));
    chk("m.overrun",    32'(overrun),    32'(m_ovr));
    chk("m.live_count", 32'(live_count), 32'((m_cnt > MAX) ? MAX : m_cnt));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Bit k of each mask drives the input sampled at window edge E(k+1).
  task automatic win(input logic [15:0] dm, input logic [15:0] rm, input logic [15:0] em);
    for (int k = 0; k < 16; k++) begin
      det = dm[k]; cnt_ready = rm[k]; enable = em[k];
      step();
    end
    det = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    thresh = 4'd3;
    repeat (3) step();
    chk("rst.cnt_out", 32'(cnt_out), 0);
    chk("rst.valid",   32'(cnt_valid), 0);
    chk("rst.overrun", 32'(overrun), 0);
    reset = 1'b0;
    step();

    // Basic count: det at E2, E5, E16.
    enable = 1'b1; cnt_ready = 1'b1;
    step();
    win(16'h8012, 16'hFFFF, 16'hFFFF);
    chk("basic.cnt_out", 32'(cnt_out), 3);
    chk("basic.valid",   32'(cnt_valid), 1);
    chk("basic.alarm",   32'(alarm), 1);
    win(16'h0000, 16'hFFFF, 16'hFFFF);
    chk("empty.cnt_out", 32'(cnt_out), 0);
    chk("empty.alarm",   32'(alarm), 0);

    // Saturation: det every edge of a 16-edge window with a 4-bit count.
    for (int k = 1; k <= 16; k++) begin
      det = 1'b1;
      step();
      if (k == 15) chk("sat.live_e15", 32'(live_count), 15);
    end
    det = 1'b0;
    chk("sat.cnt_out", 32'(cnt_out), 15);

    // Backpressure: two det per window, consumer stalled.
    thresh = 4'd2;
    enable = 1'b0; step();
    cnt_ready = 1'b0; enable = 1'b1; step();
    win(16'h0104, 16'h0000, 16'hFFFF);
    chk("bp.w1.cnt_out", 32'(cnt_out), 2);
    chk("bp.w1.overrun", 32'(overrun), 0);
    win(16'h0104, 16'h0000, 16'hFFFF);
    chk("bp.w2.cnt_out", 32'(cnt_out), 2);
    chk("bp.w2.overrun", 32'(overrun), 1);
    chk("bp.w2.alarm",   32'(alarm), 1);
    win(16'h0007, 16'h0001, 16'hFFFF);
    chk("bp.w3.cnt_out", 32'(cnt_out), 3);
    chk("bp.w3.valid",   32'(cnt_valid), 1);
    chk("bp.w3.overrun", 32'(overrun), 1);

    // Enable dropped at E10 with 4 det already counted.
    win(16'h0055, 16'hFFFF, 16'h01FF);
    chk("drop.live",    32'(live_count), 0);
    chk("drop.valid",   32'(cnt_valid), 0);
    chk("drop.overrun", 32'(overrun), 1);
    enable = 1'b1; cnt_ready = 1'b0; step();
    chk("reen.overrun", 32'(overrun), 0);
    win(16'h0001, 16'h0000, 16'hFFFF);
    chk("reen.cnt_out", 32'(cnt_out), 1);
    chk("reen.valid",   32'(cnt_valid), 1);

    // Accept coinciding with close.
    cnt_ready = 1'b1; enable = 1'b0; step();
    cnt_ready = 1'b0; enable = 1'b1; step();
    win(16'h001F, 16'h0000, 16'hFFFF);
    chk("sim.w1.cnt_out", 32'(cnt_out), 5);
    win(16'h7F00, 16'h8000, 16'hFFFF);
    chk("sim.w2.cnt_out", 32'(cnt_out), 7);
    chk("sim.w2.valid",   32'(cnt_valid), 1);
    chk("sim.w2.overrun", 32'(overrun), 0);

    // Reset mid-window with a pending result.
    repeat (5) step();
    reset = 1'b1;
    #1;
    chk("amid.cnt_out", 32'(cnt_out), 0);
    chk("amid.valid",   32'(cnt_valid), 0);
    chk("amid.live",    32'(live_count), 0);
    step();
    reset = 1'b0; enable = 1'b1;
    step();
    repeat (15) step();
    chk("arel.valid_e15", 32'(cnt_valid), 0);
    step();
    chk("arel.valid_e16", 32'(cnt_valid), 1);

    // Randomized phase with bursty ready and occasional enable drops/resets.
    for (int i = 0; i < 4000; i++) begin
      det       = 1'($urandom_range(0, 1));
      cnt_ready = ((i / 50) % 3 == 0) ? 1'b0 : ($urandom_range(0, 9) < 7);
      enable    = ($urandom_range(0, 39) != 0);
      thresh    = CW'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        #1 reset = 1'b0;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
